adc_capture_ctrl: RTL and testbench
===================================

Name: adc_capture_ctrl

Overview:
Trigger-based capture sequencer for the dual-channel ADC sample stream (12-bit ch0/ch1) that feeds the DAC loopback path. When armed, it fills a circular buffer with pre-trigger history, waits for a level-crossing or forced trigger, then records post-trigger samples and freezes. Software or a debug bridge reads the frozen window back through a registered read port indexed from the oldest sample. It sits alongside the ADC/DAC loopback in the sys_clk domain and taps the same 12-bit samples.

Parameters:
DATA_W, 12, ADC sample width per channel (two's complement)
ADDR_W, 10, buffer address width; DEPTH = 2**ADDR_W samples (each sample is the ch0/ch1 pair)

Ports:
sys_clk  in  1  sole clock; all logic is rising-edge
rst  in  1  synchronous, active-high reset
sample_valid  in  1  qualifies adc_ch0/adc_ch1 this cycle
adc_ch0  in  DATA_W  channel 0 sample
adc_ch1  in  DATA_W  channel 1 sample
arm  in  1  start capture (pulse)
abort  in  1  cancel capture (pulse)
pretrig_len  in  ADDR_W  pre-trigger sample count, latched on arm
trig_src  in  2  0=ch0 level, 1=ch1 level, 2=force only, 3=immediate
trig_edge  in  1  0=rising, 1=falling
trig_level  in  DATA_W  signed threshold, latched on arm
force_trig  in  1  software trigger (pulse)
rd_addr  in  ADDR_W  logical read index; 0 = oldest sample in window
rd_data  out  2*DATA_W  {ch1, ch0} at rd_addr, 1-cycle latency
busy  out  1  high in FILL/WAIT_TRIG/POST
done  out  1  high in DONE
triggered  out  1  trigger has occurred in the current capture
trig_addr  out  ADDR_W  physical buffer address of the trigger sample

Behaviour:
- Reset: state IDLE; busy=0, done=0, triggered=0, trig_addr=0, rd_data=0; wr_ptr=0; prev_valid=0; force_pend=0.
- Accepted sample: sample_valid=1 while in FILL, WAIT_TRIG or POST. It is written at wr_ptr, then wr_ptr = wr_ptr+1 mod DEPTH.
- States:
  - IDLE/DONE: arm -> FILL if latched pretrig_len>0, else WAIT_TRIG. On arm: clear triggered, done, prev_valid and force_pend; latch pretrig_len, trig_src, trig_edge and trig_level. wr_ptr is not reset.
  - FILL: count accepted samples. After pretrig_len samples -> WAIT_TRIG. Level crossings here are ignored. force_trig here is discarded, not latched.
  - WAIT_TRIG: keep writing circularly. The trigger sample is the first accepted sample satisfying the selected condition. On trigger: trig_addr <= its write address, triggered <= 1. Then go to POST with post_cnt = DEPTH-1-pretrig_len, or go directly to DONE if that value is 0.
  - POST: decrement post_cnt on each accepted sample; go to DONE when it reaches 0.
- Level trigger, evaluated only on accepted samples in WAIT_TRIG, signed compare on the selected channel:
  - rising: prev < level AND cur >= level.
  - falling: prev > level AND cur <= level.
  - prev is the previous accepted sample. It is invalid (no trigger possible) for the first accepted sample after arm.
- Force: in WAIT_TRIG, force_trig sets force_pend. The next accepted sample is the trigger sample; a force_trig coincident with sample_valid makes that same sample the trigger. force_trig is honoured for every trig_src.
- Immediate (trig_src=3): the first accepted sample in WAIT_TRIG is the trigger.
- Window: exactly DEPTH samples = pretrig_len before the trigger, the trigger sample, and DEPTH-1-pretrig_len after it.
  - start = trig_addr - pretrig_len mod DEPTH.
  - rd_data <= mem[start + rd_addr mod DEPTH], registered, 1-cycle latency.
  - rd_data is valid only while done=1; in other states its content is don't-care.
- arm while busy is ignored.
- abort in any state -> IDLE next cycle; busy=0, done=0, triggered=0.
- abort and arm in the same cycle: abort wins.
- Samples with sample_valid=0 are never written and never advance any counter.
- rst mid-capture: immediate return to reset values. Buffer contents are undefined.
- Memory: simple dual-port RAM, DEPTH x 2*DATA_W, one write port and one registered read port.

Test Plan:
- ADDR_W=4, pretrig_len=4, trig_src=0, rising, level=0; ch0 ramp -10,-9,… continuous, arm -> trigger on sample 0. Expect rd_addr 0->-4, 4->0, 15->11; done asserts after sample 11 is accepted; busy then low.
- Falling edge on ch1: pretrig_len=2, level=100, ch1 = 200,150,100,50… -> trigger sample 100; window starts at 200; triggered=1.
- Crossing inside FILL: pretrig_len=4, crossing at accepted sample 2, second crossing at sample 9 -> trigger at sample 9 only; trig_addr = write address of sample 9.
- trig_src=2, pretrig_len=0, force_trig with sample_valid gaps -> trigger = next accepted sample; rd_addr 0 returns it; done after 15 further accepted samples.
- abort during POST -> next cycle busy=0, done=0, triggered=0. arm pulsed while busy -> no effect. arm+abort in the same cycle from IDLE -> stays IDLE.
- rst asserted in WAIT_TRIG -> all outputs return to reset values the next cycle; subsequent arm performs a normal capture.

Source files
------------

// File: rtl/adc_capture_ctrl_if.sv
// Bundle of sample stream, capture control and read-back signals
// shared between the capture controller and whoever drives it.
interface adc_capture_ctrl_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10
) ();
  logic                     sample_valid;
  logic [DATA_W-1:0]        adc_ch0;
  logic [DATA_W-1:0]        adc_ch1;
  logic                     arm;
  logic                     abort;
  logic [ADDR_W-1:0]        pretrig_len;
  logic [1:0]               trig_src;
  logic                     trig_edge;
  logic [DATA_W-1:0]        trig_level;
  logic                     force_trig;
  logic [ADDR_W-1:0]        rd_addr;
  logic [2*DATA_W-1:0]      rd_data;
  logic                     busy;
  logic                     done;
  logic                     triggered;
  logic [ADDR_W-1:0]        trig_addr;

  modport master (
    output sample_valid, adc_ch0, adc_ch1, arm, abort, pretrig_len,
           trig_src, trig_edge, trig_level, force_trig, rd_addr,
    input  rd_data, busy, done, triggered, trig_addr
  );

  modport slave (
    input  sample_valid, adc_ch0, adc_ch1, arm, abort, pretrig_len,
           trig_src, trig_edge, trig_level, force_trig, rd_addr,
    output rd_data, busy, done, triggered, trig_addr
  );
endinterface

// File: rtl/adc_capture_ctrl.sv
// Trigger-based capture sequencer: circular pre-trigger history, level/force/immediate
// trigger, post-trigger fill, then a frozen window read back oldest-first.
module adc_capture_ctrl #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10
) (
  input logic               sys_clk,
  input logic               rst,
  adc_capture_ctrl_if.slave cap
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t                     state_r, state_nxt_s;
  logic [ADDR_W-1:0]          wr_ptr_r, pre_len_r, fill_cnt_r, post_cnt_r, trig_addr_r;
  logic [ADDR_W-1:0]          post_init_s, rd_phys_s;
  logic [1:0]                 src_r;
  logic                       edge_r;
  logic signed [DATA_W-1:0]   level_r, prev_r, cur_s;
  logic                       prev_valid_r, force_pend_r, triggered_r, busy_r, done_r;
  logic                       accept_s, arm_s, level_hit_s, trig_hit_s;
  logic [2*DATA_W-1:0]        rd_data_r;
  logic [2*DATA_W-1:0]        mem_r [DEPTH];

  // Remaining samples after the trigger so the window totals exactly DEPTH.
  assign post_init_s = {ADDR_W{1'b1}} - pre_len_r;
  assign rd_phys_s   = trig_addr_r - pre_len_r + cap.rd_addr;

  // Sample acceptance, trigger detection and next-state decode.
  always_comb begin
    accept_s    = 1'b0;
    arm_s       = 1'b0;
    level_hit_s = 1'b0;
    cur_s       = src_r[0] ? cap.adc_ch1 : cap.adc_ch0;
    state_nxt_s = state_r;

    if ((state_r == ST_FILL) || (state_r == ST_WAIT) || (state_r == ST_POST)) begin
      accept_s = cap.sample_valid;
    end else begin
      arm_s = cap.arm & ~cap.abort;
    end

    if (!src_r[1] && prev_valid_r) begin
      if (edge_r) begin
        level_hit_s = (prev_r > level_r) && (cur_s <= level_r);
      end else begin
        level_hit_s = (prev_r < level_r) && (cur_s >= level_r);
      end
    end else begin
      level_hit_s = 1'b0;
    end

    // A force pulse coincident with a sample makes that sample the trigger.
    trig_hit_s = (state_r == ST_WAIT) && accept_s &&
                 (force_pend_r || cap.force_trig || (src_r == 2'd3) || level_hit_s);

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (arm_s) begin
          state_nxt_s = (cap.pretrig_len != {ADDR_W{1'b0}}) ? ST_FILL : ST_WAIT;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_FILL: begin
        if (accept_s && (fill_cnt_r == pre_len_r - {{(ADDR_W-1){1'b0}}, 1'b1})) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_WAIT: begin
        if (trig_hit_s) begin
          state_nxt_s = (post_init_s == {ADDR_W{1'b0}}) ? ST_DONE : ST_POST;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_POST: begin
        if (accept_s && (post_cnt_r == {{(ADDR_W-1){1'b0}}, 1'b1})) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_POST;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase

    if (cap.abort) begin
      state_nxt_s = ST_IDLE;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // State, counters, trigger bookkeeping and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      triggered_r  <= 1'b0;
      trig_addr_r  <= {ADDR_W{1'b0}};
      wr_ptr_r     <= {ADDR_W{1'b0}};
      prev_valid_r <= 1'b0;
      prev_r       <= {DATA_W{1'b0}};
      force_pend_r <= 1'b0;
      pre_len_r    <= {ADDR_W{1'b0}};
      fill_cnt_r   <= {ADDR_W{1'b0}};
      post_cnt_r   <= {ADDR_W{1'b0}};
      src_r        <= 2'd0;
      edge_r       <= 1'b0;
      level_r      <= {DATA_W{1'b0}};
      rd_data_r    <= {(2*DATA_W){1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      busy_r    <= (state_nxt_s == ST_FILL) || (state_nxt_s == ST_WAIT) ||
                   (state_nxt_s == ST_POST);
      done_r    <= (state_nxt_s == ST_DONE);
      rd_data_r <= mem_r[rd_phys_s];

      if (accept_s) begin
        wr_ptr_r     <= wr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        prev_r       <= cur_s;
        prev_valid_r <= 1'b1;
      end

      if (arm_s) begin
        pre_len_r    <= cap.pretrig_len;
        src_r        <= cap.trig_src;
        edge_r       <= cap.trig_edge;
        level_r      <= cap.trig_level;
        prev_valid_r <= 1'b0;
        force_pend_r <= 1'b0;
        triggered_r  <= 1'b0;
        fill_cnt_r   <= {ADDR_W{1'b0}};
      end

      if ((state_r == ST_FILL) && accept_s) begin
        fill_cnt_r <= fill_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end

      if (trig_hit_s) begin
        trig_addr_r  <= wr_ptr_r;
        triggered_r  <= 1'b1;
        post_cnt_r   <= post_init_s;
        force_pend_r <= 1'b0;
      end else if ((state_r == ST_WAIT) && cap.force_trig) begin
        force_pend_r <= 1'b1;
      end

      if ((state_r == ST_POST) && accept_s) begin
        post_cnt_r <= post_cnt_r - {{(ADDR_W-1){1'b0}}, 1'b1};
      end

      if (cap.abort) begin
        triggered_r  <= 1'b0;
        force_pend_r <= 1'b0;
      end
    end
  end

  // Sample buffer write port; contents are not reset.
  always_ff @(posedge sys_clk) begin
    if (accept_s) begin
      mem_r[wr_ptr_r] <= {cap.adc_ch1, cap.adc_ch0};
    end
  end

  assign cap.rd_data   = rd_data_r;
  assign cap.busy      = busy_r;
  assign cap.done      = done_r;
  assign cap.triggered = triggered_r;
  assign cap.trig_addr = trig_addr_r;
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: table of capture scenarios with
// hand-computed trigger positions, plus sequences for force/abort/arm/reset cases.
module tb_adc_capture_ctrl;
  localparam int DW = 12;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   ptr_m = 0;

  adc_capture_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) cap ();

  adc_capture_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .sys_clk (clk),
    .rst     (rst),
    .cap     (cap)
  );

  always #5 clk = ~clk;

  // Sample streams are start + step*j, with j wrapping at per when per > 0.
  typedef struct {
    int pre; int src; int edg; int level;
    int c0s; int c0d; int c1s; int c1d; int per;
    int k;
  } cap_vec_t;

  cap_vec_t vecs [5];

  function automatic logic [DW-1:0] sval(input int start, input int step, input int per, input int idx);
    int j;
    j = (per > 0) ? (idx % per) : idx;
    return DW'(start + step * j);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic put(input logic v, input logic [DW-1:0] c0, input logic [DW-1:0] c1);
    cap.sample_valid = v;
    cap.adc_ch0 = c0;
    cap.adc_ch1 = c1;
    step();
    cap.sample_valid = 1'b0;
  endtask

  task automatic do_arm(input int pre, input int src, input int edg, input int level);
    cap.pretrig_len = AW'(pre);
    cap.trig_src    = 2'(src);
    cap.trig_edge   = 1'(edg);
    cap.trig_level  = DW'(level);
    cap.arm = 1'b1;
    step();
    cap.arm = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input int a, input logic [2*DW-1:0] exp);
    cap.rd_addr = AW'(a);
    step();
    chk(nm, 32'(cap.rd_data), 32'(exp));
  endtask

  task automatic run_capture(input cap_vec_t v);
    int tot;
    int base;
    int idx;
    tot  = v.k + 1 + (DEPTH - 1 - v.pre);
    base = ptr_m;
    do_arm(v.pre, v.src, v.edg, v.level);
    chk("armed_busy", 32'(cap.busy), 32'd1);
    chk("armed_trig", 32'(cap.triggered), 32'd0);
    for (int i = 0; i < tot; i++) begin
      put(1'b1, sval(v.c0s, v.c0d, v.per, i), sval(v.c1s, v.c1d, v.per, i));
      if (i == tot - 2) chk("done_early", 32'(cap.done), 32'd0);
    end
    chk("done", 32'(cap.done), 32'd1);
    chk("busy_low", 32'(cap.busy), 32'd0);
    chk("triggered", 32'(cap.triggered), 32'd1);
    chk("trig_addr", 32'(cap.trig_addr), 32'((base + v.k) % DEPTH));
    ptr_m = base + tot;
    for (int s = 0; s < 3; s++) put(1'b1, DW'(12'h7ff), DW'(12'h7ff));
    for (int r = 0; r < 3; r++) begin
      int a;
      a = (r == 0) ? 0 : ((r == 1) ? v.pre : DEPTH - 1);
      idx = v.k - v.pre + a;
      rd_chk("rd_window", a, {sval(v.c1s, v.c1d, v.per, idx), sval(v.c0s, v.c0d, v.per, idx)});
    end
  endtask

  initial begin
    int base;
    vecs[0] = '{pre:4,  src:0, edg:0, level:0,   c0s:-10, c0d:1, c1s:0,    c1d:0,   per:0, k:10};
    vecs[1] = '{pre:2,  src:1, edg:1, level:100, c0s:0,   c0d:0, c1s:200,  c1d:-50, per:0, k:2};
    vecs[2] = '{pre:0,  src:3, edg:0, level:0,   c0s:5,   c0d:3, c1s:-7,   c1d:2,   per:0, k:0};
    vecs[3] = '{pre:15, src:0, edg:0, level:20,  c0s:0,   c0d:1, c1s:300,  c1d:-1,  per:0, k:20};
    vecs[4] = '{pre:4,  src:0, edg:0, level:0,   c0s:-2,  c0d:1, c1s:1000, c1d:1,   per:7, k:9};

    cap.sample_valid = 1'b0; cap.adc_ch0 = '0; cap.adc_ch1 = '0;
    cap.arm = 1'b0; cap.abort = 1'b0; cap.pretrig_len = '0; cap.trig_src = 2'd0;
    cap.trig_edge = 1'b0; cap.trig_level = '0; cap.force_trig = 1'b0; cap.rd_addr = '0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_busy", 32'(cap.busy), 32'd0);
    chk("rst_done", 32'(cap.done), 32'd0);
    chk("rst_trig", 32'(cap.triggered), 32'd0);
    chk("rst_taddr", 32'(cap.trig_addr), 32'd0);
    chk("rst_rdata", 32'(cap.rd_data), 32'd0);

    for (int n = 0; n < 5; n++) run_capture(vecs[n]);

    // Force-only trigger across sample_valid gaps.
    base = ptr_m;
    do_arm(0, 2, 0, 0);
    put(1'b1, DW'(1), DW'(0));
    put(1'b1, DW'(2), DW'(0));
    cap.force_trig = 1'b1;
    step();
    cap.force_trig = 1'b0;
    step(); step();
    chk("force_pend_wait", 32'(cap.triggered), 32'd0);
    put(1'b1, DW'(77), DW'(0));
    chk("force_trig", 32'(cap.triggered), 32'd1);
    chk("force_taddr", 32'(cap.trig_addr), 32'((base + 2) % DEPTH));
    for (int j = 0; j < 15; j++) begin
      put(1'b1, DW'(100 + j), DW'(0));
      step();
      if (j == 13) chk("force_done_early", 32'(cap.done), 32'd0);
    end
    chk("force_done", 32'(cap.done), 32'd1);
    ptr_m = base + 18;
    rd_chk("force_rd0", 0, {12'd0, 12'd77});
    rd_chk("force_rd15", 15, {12'd0, 12'd114});

    // Abort while in POST.
    do_arm(0, 3, 0, 0);
    for (int j = 0; j < 3; j++) put(1'b1, DW'(j), DW'(0));
    ptr_m = ptr_m + 3;
    cap.abort = 1'b1;
    step();
    cap.abort = 1'b0;
    chk("abort_busy", 32'(cap.busy), 32'd0);
    chk("abort_done", 32'(cap.done), 32'd0);
    chk("abort_trig", 32'(cap.triggered), 32'd0);

    // Arm while busy must not restart the capture.
    base = ptr_m;
    do_arm(0, 3, 0, 0);
    put(1'b1, DW'(9), DW'(0));
    do_arm(8, 0, 0, 0);
    chk("rearm_busy", 32'(cap.busy), 32'd1);
    for (int j = 0; j < 14; j++) put(1'b1, DW'(j), DW'(0));
    chk("rearm_done_early", 32'(cap.done), 32'd0);
    put(1'b1, DW'(50), DW'(0));
    chk("rearm_done", 32'(cap.done), 32'd1);
    chk("rearm_taddr", 32'(cap.trig_addr), 32'(base % DEPTH));
    ptr_m = base + 16;

    // Arm and abort together from IDLE.
    cap.abort = 1'b1;
    step();
    cap.arm = 1'b1;
    step();
    cap.arm = 1'b0;
    cap.abort = 1'b0;
    chk("armabort_busy", 32'(cap.busy), 32'd0);
    put(1'b1, DW'(5), DW'(5));
    chk("armabort_idle", 32'(cap.busy), 32'd0);
    chk("armabort_done", 32'(cap.done), 32'd0);

    // Reset while waiting for a trigger, then a normal capture.
    do_arm(0, 0, 0, 0);
    put(1'b1, DW'(-5), DW'(0));
    put(1'b1, DW'(-4), DW'(0));
    chk("wait_busy", 32'(cap.busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(cap.busy), 32'd0);
    chk("mid_rst_done", 32'(cap.done), 32'd0);
    chk("mid_rst_trig", 32'(cap.triggered), 32'd0);
    chk("mid_rst_taddr", 32'(cap.trig_addr), 32'd0);
    chk("mid_rst_rdata", 32'(cap.rd_data), 32'd0);
    ptr_m = 0;
    run_capture(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
